// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller.
//   state_t : controller FSM states, 2-bit encoding
//   REG_X0  : index of the hard-wired zero register
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_HALT     = 2'd3
   } state_t;

   localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Pure combinational load-use hazard comparator.
//   i_id_ex_rd, i_id_ex_mem_read : destination and load flag of the EX instr
//   i_if_id_rs1/rs2, i_use_rs1/rs2 : sources of the ID instr and their use
//   i_if_id_mem_write            : ID instr is a store
//   o_load_use                   : ID instr must wait one cycle for the load
// ---------------------------------------------------------------------------
module load_use_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic [4:0] i_id_ex_rd,
   input  logic       i_id_ex_mem_read,
   input  logic [4:0] i_if_id_rs1,
   input  logic [4:0] i_if_id_rs2,
   input  logic       i_use_rs1,
   input  logic       i_use_rs2,
   input  logic       i_if_id_mem_write,
   output logic       o_load_use
);

   logic w_hit_rs1;
   logic w_hit_rs2;

   assign w_hit_rs1 = (i_id_ex_rd == i_if_id_rs1) && i_use_rs1;
   // A store's data operand (rs2) is forwarded at MEM, so it never stalls.
   assign w_hit_rs2 = (i_id_ex_rd == i_if_id_rs2) && i_use_rs2 && !i_if_id_mem_write;

   assign o_load_use = i_id_ex_mem_read && (i_id_ex_rd != REG_X0) && (w_hit_rs1 || w_hit_rs2);

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Stall/flush controller for a 5-stage RISC-V pipeline: load-use stall,
// data-memory freeze, taken-branch flush, memory-timeout watchdog and
// saturating performance counters.
//   Inputs : hazard info from IF/ID and ID/EX, EX_branch_taken, dmem_req/ready
//   Outputs: pc/pipe-register write enables, MEM_WB_bubble, control_mux_sel,
//            IF_ID/ID_EX flushes, sticky mem_timeout, stall_cycles,
//            flush_events, o_dbg_state (current FSM state)
// Control outputs are combinational from state + inputs (zero-cycle response).
// ---------------------------------------------------------------------------
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       IF_ID_rs1,
   input  logic [4:0]       IF_ID_rs2,
   input  logic             IF_ID_use_rs1,
   input  logic             IF_ID_use_rs2,
   input  logic             IF_ID_mem_write,
   input  logic [4:0]       ID_EX_rd,
   input  logic             ID_EX_mem_read,
   input  logic             EX_branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             IF_ID_write,
   output logic             ID_EX_write,
   output logic             EX_MEM_write,
   output logic             MEM_WB_bubble,
   output logic             control_mux_sel,
   output logic             IF_ID_flush,
   output logic             ID_EX_flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events,
   output logic [1:0]       o_dbg_state
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [WAIT_W-1:0] w_wait_next;
   logic [WAIT_W-1:0] w_wait_inc;
   logic              r_mem_timeout;
   logic              w_set_timeout;
   logic [CNT_W-1:0]  r_stall_cycles;
   logic [CNT_W-1:0]  r_flush_events;
   logic              w_load_use;
   logic              w_frozen;
   logic              w_count_stall;
   logic              w_count_flush;

   load_use_detect u_load_use_detect (
      .i_id_ex_rd        (ID_EX_rd),
      .i_id_ex_mem_read  (ID_EX_mem_read),
      .i_if_id_rs1       (IF_ID_rs1),
      .i_if_id_rs2       (IF_ID_rs2),
      .i_use_rs1         (IF_ID_use_rs1),
      .i_use_rs2         (IF_ID_use_rs2),
      .i_if_id_mem_write (IF_ID_mem_write),
      .o_load_use        (w_load_use)
   );

   assign w_wait_inc = r_wait_cnt + WAIT_W'(1);

   // RUN enters the freeze on a pending access; MEM_WAIT holds it until ready.
   assign w_frozen = ((r_state == ST_RUN) && dmem_req && !dmem_ready) ||
                     ((r_state == ST_MEM_WAIT) && !dmem_ready);

   always_comb begin
      pc_write        = 1'b0;
      IF_ID_write     = 1'b0;
      ID_EX_write     = 1'b0;
      EX_MEM_write    = 1'b0;
      MEM_WB_bubble   = 1'b0;
      control_mux_sel = 1'b0;
      IF_ID_flush     = 1'b0;
      ID_EX_flush     = 1'b0;
      w_state_next    = r_state;
      w_wait_next     = r_wait_cnt;
      w_set_timeout   = 1'b0;
      w_count_stall   = 1'b0;
      w_count_flush   = 1'b0;
      case (r_state)
         ST_INIT: begin
            control_mux_sel = 1'b1;
            w_state_next    = ST_RUN;
            w_wait_next     = '0;
         end
         ST_RUN, ST_MEM_WAIT: begin
            if (w_frozen) begin
               MEM_WB_bubble = 1'b1;
               w_count_stall = 1'b1;
               // The RUN cycle that detects the wait is the first not-ready cycle.
               w_wait_next   = (r_state == ST_RUN) ? WAIT_W'(1) : w_wait_inc;
               if (w_wait_next >= WAIT_W'(MEM_TIMEOUT)) begin
                  w_state_next  = ST_HALT;
                  w_set_timeout = 1'b1;
               end else begin
                  w_state_next = ST_MEM_WAIT;
               end
            end else begin
               w_state_next = ST_RUN;
               w_wait_next  = '0;
               pc_write     = 1'b1;
               IF_ID_write  = 1'b1;
               ID_EX_write  = 1'b1;
               EX_MEM_write = 1'b1;
               if (EX_branch_taken) begin
                  // The ID instruction is flushed, so its load-use hazard is moot.
                  IF_ID_flush   = 1'b1;
                  ID_EX_flush   = 1'b1;
                  w_count_flush = 1'b1;
               end else if (w_load_use) begin
                  pc_write        = 1'b0;
                  IF_ID_write     = 1'b0;
                  control_mux_sel = 1'b1;
                  w_count_stall   = 1'b1;
               end
            end
         end
         ST_HALT: begin
            MEM_WB_bubble = 1'b1;
         end
         default: begin
            w_state_next = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_INIT;
         r_wait_cnt     <= '0;
         r_mem_timeout  <= 1'b0;
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else begin
         r_state       <= w_state_next;
         r_wait_cnt    <= w_wait_next;
         r_mem_timeout <= r_mem_timeout | w_set_timeout;
         if (w_count_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         end
         if (w_count_flush && (r_flush_events != '1)) begin
            r_flush_events <= r_flush_events + CNT_W'(1);
         end
      end
   end

   assign mem_timeout  = r_mem_timeout;
   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;
   assign o_dbg_state  = r_state;

endmodule
